// File: rtl/periph_arb_pkg.sv
// ---------------------------------------------------------------------------
// periph_arb_pkg
// Shared definitions for the peripheral round-robin arbiter slice.
//   idx_width()  : index width for a count of items, never less than 1
//   arb_state_e  : lock state of the arbiter (UNLOCKED / LOCKED)
// ---------------------------------------------------------------------------
package periph_arb_pkg;

    // Width needed to index n items. For n <= 2 this is forced to 1 so that
    // degenerate configurations still get a real (non-zero-width) vector.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/periph_arb_route_fifo.sv
// ---------------------------------------------------------------------------
// periph_arb_route_fifo
// Small in-order FIFO holding the master index of every accepted request so
// the matching response can be steered back.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, data_i: write an index (ignored when full)
//   pop_i, data_o : drop the head entry (ignored when empty); data_o is the
//                   head, readable combinationally
//   full_o, empty_o, count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module periph_arb_route_fifo
    import periph_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PW   = idx_width(DEPTH),
    localparam int CW   = idx_width(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_en);
        rd_ptr_d = rd_ptr_q + PW'(pop_en);
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/periph_rr_arbiter.sv
// ---------------------------------------------------------------------------
// periph_rr_arbiter
// N-to-1 round-robin arbiter in front of the peripheral request FIFO. The
// granted master index is recorded per accepted request and used to steer the
// in-order responses back to their originator. At most MAX_OUTSTANDING
// requests may be in flight.
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   data_req_i .. data_be_i     : per-master request and payload
//   data_gnt_o, data_r_valid_o  : per-master grant / response valid
//   data_r_opc_o, data_r_rdata_o: response broadcast to all masters
//   data_req_o .. data_be_o     : muxed request towards the FIFO
//   data_gnt_i                  : FIFO can take a request this cycle
//   data_r_valid_i/opc/rdata    : responses, in request order
// Optional build macro PERIPH_RR_ARB_ERR_EN adds err_o, a sticky flag raised
// on a response with nothing outstanding or a locked master dropping its
// request. Cleared only by reset.
// ---------------------------------------------------------------------------
module periph_rr_arbiter
    import periph_arb_pkg::*;
#(
    parameter int NB_MASTERS      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_ENABLE_BIT = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NB_MASTERS-1:0]                       data_req_i,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]       data_add_i,
    input  logic [NB_MASTERS-1:0]                       data_we_n_i,
    input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]       data_wdata_i,
    input  logic [NB_MASTERS-1:0][BYTE_ENABLE_BIT-1:0]  data_be_i,
    output logic [NB_MASTERS-1:0]                       data_gnt_o,
    output logic [NB_MASTERS-1:0]                       data_r_valid_o,
    output logic                                        data_r_opc_o,
    output logic [DATA_WIDTH-1:0]                       data_r_rdata_o,
    output logic                                        data_req_o,
    output logic [ADDR_WIDTH-1:0]                       data_add_o,
    output logic                                        data_we_n_o,
    output logic [DATA_WIDTH-1:0]                       data_wdata_o,
    output logic [BYTE_ENABLE_BIT-1:0]                  data_be_o,
    input  logic                                        data_gnt_i,
    input  logic                                        data_r_valid_i,
    input  logic                                        data_r_opc_i,
    input  logic [DATA_WIDTH-1:0]                       data_r_rdata_i
`ifdef PERIPH_RR_ARB_ERR_EN
    ,
    output logic                                        err_o
`endif
);

    localparam int IW = idx_width(NB_MASTERS);
    localparam int CW = idx_width(MAX_OUTSTANDING + 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   head_idx;
    logic            route_full, route_empty;
    logic [CW-1:0]   unused_route_count;
    logic            accept;
    logic            found;
    int              cand;

    // Winner search: first requester at or after the RR pointer. While locked
    // the stalled master is pinned so its payload stays on the bus.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        cand   = 0;
        if (state_q == LOCKED) begin
            winner = lock_idx_q;
        end else begin
            for (int i = 0; i < NB_MASTERS; i++) begin
                cand = int'(rr_q) + i;
                if (cand >= NB_MASTERS) begin
                    cand = cand - NB_MASTERS;
                end
                if (!found && data_req_i[cand]) begin
                    winner = IW'(cand);
                    found  = 1'b1;
                end
            end
        end
    end

    // Full blocks new requests even if a response frees a slot this cycle.
    assign data_req_o   = (|data_req_i) & ~route_full;
    assign accept       = data_req_o & data_gnt_i;
    assign data_add_o   = data_add_i[winner];
    assign data_we_n_o  = data_we_n_i[winner];
    assign data_wdata_o = data_wdata_i[winner];
    assign data_be_o    = data_be_i[winner];

    assign data_r_opc_o   = data_r_opc_i;
    assign data_r_rdata_o = data_r_rdata_i;

    for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_master
        assign data_gnt_o[gi]     = accept & (winner == IW'(gi));
        // A response with nothing outstanding goes nowhere.
        assign data_r_valid_o[gi] = data_r_valid_i & ~route_empty & (head_idx == IW'(gi));
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        case (state_q)
            UNLOCKED: begin
                if (data_req_o && !data_gnt_i) begin
                    state_d    = LOCKED;
                    lock_idx_d = winner;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
        if (accept) begin
            rr_d = (winner == IW'(NB_MASTERS - 1)) ? '0 : winner + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= UNLOCKED;
            lock_idx_q <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
        end
    end

    periph_arb_route_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (data_r_valid_i),
        .data_o  (head_idx),
        .full_o  (route_full),
        .empty_o (route_empty),
        .count_o (unused_route_count)
    );

`ifdef PERIPH_RR_ARB_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (data_r_valid_i & route_empty)
              | ((state_q == LOCKED) & ~data_req_i[lock_idx_q]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_periph_rr_arbiter.sv
module tb_periph_rr_arbiter;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [NB-1:0]        data_req_i;
    logic [NB-1:0][AW-1:0] data_add_i;
    logic [NB-1:0]        data_we_n_i;
    logic [NB-1:0][DW-1:0] data_wdata_i;
    logic [NB-1:0][BW-1:0] data_be_i;
    logic [NB-1:0]        data_gnt_o;
    logic [NB-1:0]        data_r_valid_o;
    logic                 data_r_opc_o;
    logic [DW-1:0]        data_r_rdata_o;
    logic                 data_req_o;
    logic [AW-1:0]        data_add_o;
    logic                 data_we_n_o;
    logic [DW-1:0]        data_wdata_o;
    logic [BW-1:0]        data_be_o;
    logic                 data_gnt_i;
    logic                 data_r_valid_i;
    logic                 data_r_opc_i;
    logic [DW-1:0]        data_r_rdata_i;
`ifdef PERIPH_RR_ARB_ERR_EN
    logic                 err_o;
`endif

    int checks = 0;
    int errors = 0;
    int route_q[$];   // expected master index of each outstanding request

    always #5 clk = ~clk;

    periph_rr_arbiter #(
        .NB_MASTERS      (NB),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BYTE_ENABLE_BIT (BW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_we_n_i    (data_we_n_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_req_o     (data_req_o),
        .data_add_o     (data_add_o),
        .data_we_n_o    (data_we_n_o),
        .data_wdata_o   (data_wdata_o),
        .data_be_o      (data_be_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_valid_i (data_r_valid_i),
        .data_r_opc_i   (data_r_opc_i),
        .data_r_rdata_i (data_r_rdata_i)
`ifdef PERIPH_RR_ARB_ERR_EN
        ,
        .err_o          (err_o)
`endif
    );

    function automatic logic [AW-1:0] addr_of(input int m);
        return 32'hA000_0000 + AW'(m * 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni         = 1'b0;
        data_req_i     = '0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_opc_i   = 1'b0;
        data_r_rdata_i = '0;
        for (int m = 0; m < NB; m++) begin
            data_add_i[m]   = '0;
            data_wdata_i[m] = '0;
            data_be_i[m]    = '0;
            data_we_n_i[m]  = 1'b0;
        end
        tick();
        @(negedge clk);
        checks++;
        if (data_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b want 0", data_req_o);
        end
        checks++;
        if ({data_gnt_o, data_r_valid_o} !== '0) begin
            errors++; $display("FAIL reset_gnt_rvalid got %b want 0", {data_gnt_o, data_r_valid_o});
        end
        checks++;
        if ({data_add_o, data_we_n_o, data_wdata_o, data_be_o, data_r_opc_o, data_r_rdata_o} !== '0) begin
            errors++; $display("FAIL reset_payload got %h want 0",
                {data_add_o, data_we_n_o, data_wdata_o, data_be_o, data_r_opc_o, data_r_rdata_o});
        end
`ifdef PERIPH_RR_ARB_ERR_EN
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b want 0", err_o);
        end
`endif
        tick();
        rst_ni = 1'b1;
        // Distinct payload per master so the mux selection is visible.
        for (int m = 0; m < NB; m++) begin
            data_add_i[m]   = addr_of(m);
            data_wdata_i[m] = 32'hD000_0000 + DW'(m);
            data_be_i[m]    = BW'(m + 1);
            data_we_n_i[m]  = m[0];
        end
    endtask

    // Pops one expected index per response and checks steering + passthrough.
    task automatic drain(input int n, input string tag);
        int exp;
        for (int k = 0; k < n; k++) begin
            data_r_valid_i = 1'b1;
            data_r_opc_i   = k[0];
            data_r_rdata_i = 32'h5A00_0000 + DW'(k);
            exp = route_q.pop_front();
            @(negedge clk);
            $display("%s: response %0d -> master %0d", tag, k, exp);
            checks++;
            if (data_r_valid_o !== NB'(1 << exp)) begin
                errors++; $display("FAIL %s_rvalid%0d got %b want %b", tag, k, data_r_valid_o, NB'(1 << exp));
            end
            checks++;
            if ({data_r_opc_o, data_r_rdata_o} !== {k[0], 32'h5A00_0000 + DW'(k)}) begin
                errors++; $display("FAIL %s_rdata%0d got %h want %h", tag, k,
                    {data_r_opc_o, data_r_rdata_o}, {k[0], 32'h5A00_0000 + DW'(k)});
            end
            tick();
        end
        data_r_valid_i = 1'b0;
    endtask

    task automatic test_alternate();
        int exp;
        data_gnt_i = 1'b1;
        data_req_i = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 0 : 2;
            route_q.push_back(exp);
            @(negedge clk);
            $display("alternate: accept %0d expect master %0d", k, exp);
            checks++;
            if (data_gnt_o !== NB'(1 << exp) || data_add_o !== addr_of(exp)) begin
                errors++; $display("FAIL alt_gnt%0d got %b/%h want %b/%h", k, data_gnt_o, data_add_o,
                    NB'(1 << exp), addr_of(exp));
            end
            tick();
        end
        data_req_i = '0;
        drain(4, "alternate");
    endtask

    task automatic test_lock();
        data_gnt_i = 1'b0;
        data_req_i = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) data_req_i = 4'b1010;
            @(negedge clk);
            $display("lock: stall cycle %0d", k);
            checks++;
            if (data_req_o !== 1'b1 || data_gnt_o !== '0 || data_add_o !== addr_of(1)) begin
                errors++; $display("FAIL lock_hold%0d got req=%b gnt=%b add=%h want 1/0000/%h",
                    k, data_req_o, data_gnt_o, data_add_o, addr_of(1));
            end
            tick();
        end
        data_gnt_i = 1'b1;
        route_q.push_back(1);
        @(negedge clk);
        checks++;
        if (data_gnt_o !== 4'b0010 || data_add_o !== addr_of(1)) begin
            errors++; $display("FAIL lock_release got %b/%h want 0010/%h", data_gnt_o, data_add_o, addr_of(1));
        end
        tick();
        data_req_i = 4'b1000;
        route_q.push_back(3);
        @(negedge clk);
        checks++;
        if (data_gnt_o !== 4'b1000 || data_add_o !== addr_of(3)) begin
            errors++; $display("FAIL lock_next got %b/%h want 1000/%h", data_gnt_o, data_add_o, addr_of(3));
        end
        tick();
        data_req_i = '0;
        drain(2, "lock");
    endtask

    task automatic test_full();
        data_gnt_i = 1'b1;
        data_req_i = 4'b1111;
        for (int k = 0; k < MO; k++) begin
            route_q.push_back(k);
            @(negedge clk);
            $display("full: accept %0d expect master %0d", k, k);
            checks++;
            if (data_gnt_o !== NB'(1 << k)) begin
                errors++; $display("FAIL full_gnt%0d got %b want %b", k, data_gnt_o, NB'(1 << k));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (data_req_o !== 1'b0 || data_gnt_o !== '0) begin
            errors++; $display("FAIL full_block got req=%b gnt=%b want 0/0000", data_req_o, data_gnt_o);
        end
        tick();
        // Response frees a slot, but no bypass: still blocked this cycle.
        data_r_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req_o !== 1'b0 || data_r_valid_o !== NB'(1 << route_q[0])) begin
            errors++; $display("FAIL full_pop got req=%b rvalid=%b want 0/%b", data_req_o, data_r_valid_o,
                NB'(1 << route_q[0]));
        end
        void'(route_q.pop_front());
        tick();
        data_r_valid_i = 1'b0;
        route_q.push_back(0);
        @(negedge clk);
        $display("full: refill accept expect master 0");
        checks++;
        if (data_req_o !== 1'b1 || data_gnt_o !== 4'b0001) begin
            errors++; $display("FAIL full_refill got req=%b gnt=%b want 1/0001", data_req_o, data_gnt_o);
        end
        tick();
        data_req_i = '0;
    endtask

    task automatic test_push_pop();
        drain(2, "pushpop_pre");
        // Two outstanding; accept and response together.
        data_req_i     = 4'b0100;
        data_r_valid_i = 1'b1;
        @(negedge clk);
        $display("pushpop: accept master 2 with response to master %0d", route_q[0]);
        checks++;
        if (data_gnt_o !== 4'b0100 || data_r_valid_o !== NB'(1 << route_q[0])) begin
            errors++; $display("FAIL pushpop_same got gnt=%b rvalid=%b want 0100/%b",
                data_gnt_o, data_r_valid_o, NB'(1 << route_q[0]));
        end
        void'(route_q.pop_front());
        route_q.push_back(2);
        tick();
        data_r_valid_i = 1'b0;
        // Count must still be 2: exactly two more accepts fit.
        data_req_i = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            route_q.push_back(k == 0 ? 3 : 0);
            @(negedge clk);
            checks++;
            if (data_gnt_o !== (k == 0 ? 4'b1000 : 4'b0001)) begin
                errors++; $display("FAIL pushpop_fill%0d got %b want %b", k, data_gnt_o,
                    (k == 0 ? 4'b1000 : 4'b0001));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (data_req_o !== 1'b0) begin
            errors++; $display("FAIL pushpop_count got req=%b want 0", data_req_o);
        end
        tick();
        data_req_i = '0;
        drain(4, "pushpop");
    endtask

    task automatic test_empty_resp();
        data_r_valid_i = 1'b1;
        @(negedge clk);
        $display("empty: stray response");
        checks++;
        if (data_r_valid_o !== '0) begin
            errors++; $display("FAIL empty_rvalid got %b want 0000", data_r_valid_o);
        end
        tick();
        data_r_valid_i = 1'b0;
`ifdef PERIPH_RR_ARB_ERR_EN
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL empty_err_set got %b want 1", err_o);
        end
        tick();
        tick();
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL empty_err_sticky got %b want 1", err_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL empty_err_clear got %b want 0", err_o);
        end
        rst_ni = 1'b1;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        data_gnt_i = 1'b1;
        data_req_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (data_gnt_o !== 4'b0100) begin
                errors++; $display("FAIL rstmid_gnt%0d got %b want 0100", k, data_gnt_o);
            end
            tick();
        end
        data_req_i = '0;
        rst_ni     = 1'b0;
        #1;
        $display("reset_mid: reset with 3 outstanding");
        checks++;
        if (data_req_o !== 1'b0 || data_gnt_o !== '0) begin
            errors++; $display("FAIL rstmid_async got req=%b gnt=%b want 0/0000", data_req_o, data_gnt_o);
        end
        tick();
        rst_ni     = 1'b1;
        data_req_i = 4'b1010;
        route_q.push_back(1);
        @(negedge clk);
        checks++;
        if (data_gnt_o !== 4'b0010) begin
            errors++; $display("FAIL rstmid_first got %b want 0010", data_gnt_o);
        end
        tick();
        data_req_i = '0;
        drain(1, "reset_mid");
        data_r_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (data_r_valid_o !== '0) begin
            errors++; $display("FAIL rstmid_stale got %b want 0000", data_r_valid_o);
        end
        tick();
        data_r_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_push_pop();
        test_empty_resp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
